seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: CHECK_DP, default 1, nonzero = decimal-point bit codificacion[7] must be 1 (off), else pattern invalid.
REQ-002 Parameter: STABLE_FRAMES, default 2, range 1..15, consecutive identical good frames required to assert stable.
REQ-003 clk_d  input  1  scan clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 codificacion  input  8  segment code, active-low: bit7=dp, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-006 digito  input  4  one-hot digit strobe: 4'd1 = units, 4'd2 = tens, 4'd4 = hundreds, 4'd8 = thousands.
REQ-007 value  output  14  binary value of the last good frame.
REQ-008 frame_valid  output  1  one-cycle pulse when value is updated.
REQ-009 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-010 stable  output  1  level, high once STABLE_FRAMES consecutive good frames carry equal values.
REQ-011 err_count  output  8  count of frame_err pulses, saturating at 255.

Function
REQ-012 Inputs are sampled every clk_d edge; there is no oversampling and no synchronizer.
REQ-013 Decode table, bits[6:0]: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
REQ-014 Blank decodes as 0 in slots 1-3; blank in slot 0 is invalid; any other pattern is invalid.
REQ-015 Capture pointer exp (0..3): digito==4'd0 is ignored, with no state change.
REQ-016 digito equal to one-hot(exp): store decoded digit and bad flag in slot exp, then exp += 1 (3 wraps to 0).
REQ-017 digito==4'd1 while exp!=0: frame_err, old frame dropped, sample stored as slot 0, exp=1.
REQ-018 Any other digito value (wrong one-hot or non-one-hot): frame_err, exp=0.
REQ-019 Slot 3 stored with all slots good: slots copy to the conversion buffer on that edge (T); capture continues without stall.
REQ-020 Slot 3 stored with any slot bad: frame_err on the next cycle; no conversion.
REQ-021 Conversion FSM states: IDLE -> C3 -> C2 -> C1 -> C0 -> IDLE.
REQ-022 Conversion steps: edge T+1 acc=d3; T+2 acc=acc*10+d2; T+3 acc=acc*10+d1; T+4 value=acc*10+d0, frame_valid=1.
REQ-023 Arithmetic is unsigned 14-bit; maximum result is 9999, so no overflow occurs.
REQ-024 value holds its contents between updates and is unchanged by frame_err.
REQ-025 A new good frame cannot complete during conversion, since 4 capture edges are at least 4 conversion edges; no buffering beyond one frame.
REQ-026 Stable counter on each frame_valid: new value equals previous value -> increment, saturating at 15; otherwise set to 1.
REQ-027 stable = (counter >= STABLE_FRAMES); it updates on the same edge as frame_valid.
REQ-028 frame_err clears the stable counter and stable on the same edge.
REQ-029 frame_err pulses are single-cycle; simultaneous error sources in one cycle give one pulse and one err_count increment.
REQ-030 frame_valid and frame_err in the same cycle are allowed: the conversion completes and the capture errs independently.

Reset
REQ-031 reset high at an edge: value=0, frame_valid=0, frame_err=0, stable=0, err_count=0, stable counter=0, exp=0, FSM=IDLE, slots and bad flags cleared.
REQ-032 reset has priority over all sampling.
REQ-033 reset during conversion aborts it: no frame_valid pulse.
REQ-034 Inputs sampled on the reset edge are discarded.
REQ-035 The first edge after reset deasserts samples normally.

Verification
REQ-036 Digit 125 frame: digito 1,2,4,8 with codificacion 10100100, 10010010, 11001111, 11111111 -> value=125, frame_valid exactly 4 edges after the digito=8 sample.
REQ-037 Frame 0,0,0,1 (10000001 x3, then 11001111) -> value=1000; frame 10000001 then three blanks -> value=0.
REQ-038 Slot 1 = 11110000 in an otherwise good frame -> frame_err one cycle after the digito=8 sample, value unchanged, err_count=1.
REQ-039 digito 1 then 4 -> frame_err on the digito=4 sample; following clean 350 frame -> value=350.
REQ-040 Back-to-back frames 300, 300 with STABLE_FRAMES=2 -> stable=1 at the second frame_valid; next frame 400 -> stable=0; frame_err -> stable=0.
REQ-041 reset at edge T+2 of a conversion -> no frame_valid, all outputs 0; err_count saturates at 255 after 300 forced errors.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 4-digit seven-segment scan decoder: captures one digit per strobe,
// converts a good frame to binary over four cycles and tracks frame stability.
module seg7_scan_decoder #(
  parameter int CHECK_DP      = 1,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk_d,
  input  logic        reset,
  input  logic [7:0]  codificacion,
  input  logic [3:0]  digito,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stable,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {S_IDLE, S_C3, S_C2, S_C1, S_C0} state_t;

  localparam logic [3:0] STABLE_TH = 4'(STABLE_FRAMES);

  // Returns {ok, blank, digit}; segments are active-low a..g.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {2'b10, 4'd0};
      7'b1001111: seg_decode = {2'b10, 4'd1};
      7'b0010010: seg_decode = {2'b10, 4'd2};
      7'b0000110: seg_decode = {2'b10, 4'd3};
      7'b1001100: seg_decode = {2'b10, 4'd4};
      7'b0100100: seg_decode = {2'b10, 4'd5};
      7'b0100000: seg_decode = {2'b10, 4'd6};
      7'b0001111: seg_decode = {2'b10, 4'd7};
      7'b0000000: seg_decode = {2'b10, 4'd8};
      7'b0000100: seg_decode = {2'b10, 4'd9};
      7'b1111111: seg_decode = {2'b11, 4'd0};
      default:    seg_decode = {2'b00, 4'd0};
    endcase
  endfunction

  function automatic logic [13:0] mac10(input logic [13:0] acc, input logic [3:0] d);
    mac10 = (acc << 3) + (acc << 1) + {10'd0, d};
  endfunction

  logic [1:0]  r_exp;
  logic [3:0]  r_d0, r_d1, r_d2;
  logic [2:0]  r_bad;
  logic        r_bad_pend;
  logic [15:0] r_buf;
  logic [13:0] r_acc;
  logic [3:0]  r_cnt;
  state_t      r_state, w_next;

  logic [5:0]  w_dec;
  logic [3:0]  w_onehot;
  logic        w_store, w_restart, w_seq_err, w_bad, w_last, w_start, w_err, w_conv_done;
  logic [1:0]  w_slot;
  logic [13:0] w_new_value;
  logic [3:0]  w_cnt_next;

  assign w_dec     = seg_decode(codificacion[6:0]);
  assign w_onehot  = 4'd1 << r_exp;
  assign w_store   = (digito == w_onehot) || (digito == 4'd1);
  assign w_restart = (digito == 4'd1) && (r_exp != 2'd0);
  assign w_seq_err = (digito != 4'd0) && !w_store;
  assign w_slot    = (digito == 4'd1) ? 2'd0 : r_exp;
  // A blank is a leading zero, but the units digit is always lit.
  assign w_bad     = !w_dec[5] || ((CHECK_DP != 0) && !codificacion[7]) ||
                     (w_dec[4] && (w_slot == 2'd0));
  assign w_last    = w_store && (w_slot == 2'd3);
  assign w_start   = w_last && !w_bad && (r_bad == 3'b000);
  assign w_err     = w_seq_err || w_restart || r_bad_pend;

  assign w_conv_done = (r_state == S_C0);
  assign w_new_value = mac10(r_acc, r_buf[3:0]);
  assign w_cnt_next  = (w_new_value != value) ? 4'd1 :
                       (r_cnt == 4'd15)       ? 4'd15 : r_cnt + 4'd1;

  // Capture stage: one slot per strobe, slot 3 hands the frame to conversion
  always_ff @(posedge clk_d) begin
    if (reset) begin
      r_exp      <= 2'd0;
      r_d0       <= 4'd0;
      r_d1       <= 4'd0;
      r_d2       <= 4'd0;
      r_bad      <= 3'b000;
      r_bad_pend <= 1'b0;
      r_buf      <= 16'd0;
    end else begin
      r_bad_pend <= w_last && !w_start;
      if (w_store) begin
        case (w_slot)
          2'd0:    begin r_d0 <= w_dec[3:0]; r_bad[0] <= w_bad; end
          2'd1:    begin r_d1 <= w_dec[3:0]; r_bad[1] <= w_bad; end
          2'd2:    begin r_d2 <= w_dec[3:0]; r_bad[2] <= w_bad; end
          default: ;
        endcase
        r_exp <= w_slot + 2'd1;
      end else if (digito != 4'd0) begin
        r_exp <= 2'd0;
      end
      if (w_start) r_buf <= {w_dec[3:0], r_d2, r_d1, r_d0};
    end
  end

  always_ff @(posedge clk_d) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_C3:    w_next = S_C2;
      S_C2:    w_next = S_C1;
      S_C1:    w_next = S_C0;
      S_C0:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // A new frame can only complete while idle or on the final conversion step.
    if (w_start) w_next = S_C3;
  end

  // Conversion stage: most significant digit first, acc = acc*10 + d
  always_ff @(posedge clk_d) begin
    if (reset) begin
      r_acc       <= 14'd0;
      value       <= 14'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (r_state)
        S_C3:    r_acc <= {10'd0, r_buf[15:12]};
        S_C2:    r_acc <= mac10(r_acc, r_buf[11:8]);
        S_C1:    r_acc <= mac10(r_acc, r_buf[7:4]);
        S_C0:    begin value <= w_new_value; frame_valid <= 1'b1; end
        default: ;
      endcase
    end
  end

  // Status stage: error pulse/count and stability tracking
  always_ff @(posedge clk_d) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= 8'd0;
      r_cnt     <= 4'd0;
      stable    <= 1'b0;
    end else begin
      frame_err <= w_err;
      if (w_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (w_err) begin
        r_cnt  <= 4'd0;
        stable <= 1'b0;
      end else if (w_conv_done) begin
        r_cnt  <= w_cnt_next;
        stable <= (w_cnt_next >= STABLE_TH);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with default parameters (CHECK_DP=1, STABLE_FRAMES=2).
module tb_seg7_scan_decoder;

  logic        clk_d = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  codificacion = 8'hFF;
  logic [3:0]  digito = 4'd0;
  logic [13:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic        stable;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  seg7_scan_decoder dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .codificacion (codificacion),
    .digito       (digito),
    .value        (value),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .stable       (stable),
    .err_count    (err_count)
  );

  always #5 clk_d = ~clk_d;

  task automatic step(input logic [7:0] c, input logic [3:0] d);
    codificacion = c;
    digito = d;
    @(posedge clk_d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'hFF, 4'd0);
  endtask

  task automatic send_frame(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    step(c0, 4'd1);
    step(c1, 4'd2);
    step(c2, 4'd4);
    step(c3, 4'd8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(8'hA4, 4'd1);
    step(8'h92, 4'd2);
    reset = 1'b0;
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL reset_value got=%0d exp=0", value); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable got=%b exp=0", stable); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
  endtask

  task automatic test_frame_125();
    send_frame(8'hA4, 8'h92, 8'hCF, 8'hFF);
    for (int i = 1; i <= 3; i++) begin
      step(8'hFF, 4'd0);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL f125_early_fv edge=%0d got=%b exp=0", i, frame_valid); end
    end
    step(8'hFF, 4'd0);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL f125_fv got=%b exp=1", frame_valid); end
    checks++; if (value !== 14'd125) begin errors++; $display("FAIL f125_value got=%0d exp=125", value); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL f125_stable got=%b exp=0", stable); end
    step(8'hFF, 4'd0);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL f125_pulse got=%b exp=0", frame_valid); end
  endtask

  task automatic test_frame_zero_1000();
    send_frame(8'h81, 8'hFF, 8'hFF, 8'hFF);
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd0) begin errors++; $display("FAIL f0_value got=%0d fv=%b exp=0 fv=1", value, frame_valid); end
    send_frame(8'h81, 8'h81, 8'h81, 8'hCF);
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd1000) begin errors++; $display("FAIL f1000_value got=%0d fv=%b exp=1000 fv=1", value, frame_valid); end
  endtask

  task automatic test_bad_slot();
    send_frame(8'h81, 8'hF0, 8'h81, 8'h81);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_fe_early got=%b exp=0", frame_err); end
    step(8'hFF, 4'd0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_fe got=%b exp=1", frame_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_errcnt got=%0d exp=1", err_count); end
    checks++; if (value !== 14'd1000) begin errors++; $display("FAIL bad_value got=%0d exp=1000", value); end
    step(8'hFF, 4'd0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_fe_pulse got=%b exp=0", frame_err); end
    idle(3);
    checks++; if (frame_valid !== 1'b0 || value !== 14'd1000) begin errors++; $display("FAIL bad_noconv got=%0d fv=%b exp=1000 fv=0", value, frame_valid); end
    // Decimal point lit on the units digit
    send_frame(8'h06, 8'h81, 8'h81, 8'h81);
    step(8'hFF, 4'd0);
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL dp_err got fe=%b cnt=%0d exp fe=1 cnt=2", frame_err, err_count); end
  endtask

  task automatic test_seq_err();
    step(8'h81, 4'd1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL seq_fe_early got=%b exp=0", frame_err); end
    step(8'h81, 4'd4);
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL seq_fe got fe=%b cnt=%0d exp fe=1 cnt=3", frame_err, err_count); end
    send_frame(8'h81, 8'hA4, 8'h86, 8'hFF);
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd350) begin errors++; $display("FAIL seq_350 got=%0d fv=%b exp=350 fv=1", value, frame_valid); end
    // Units strobe in mid-frame restarts capture with that sample as slot 0
    step(8'h81, 4'd1);
    step(8'h81, 4'd2);
    step(8'hA4, 4'd1);
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd4) begin errors++; $display("FAIL restart_fe got fe=%b cnt=%0d exp fe=1 cnt=4", frame_err, err_count); end
    step(8'h92, 4'd2);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL restart_fe_pulse got=%b exp=0", frame_err); end
    step(8'hCF, 4'd4);
    step(8'hFF, 4'd8);
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd125) begin errors++; $display("FAIL restart_125 got=%0d fv=%b exp=125 fv=1", value, frame_valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h81, 8'h81, 8'h86, 8'hFF);
    send_frame(8'h81, 8'h81, 8'h86, 8'hFF);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd300 || stable !== 1'b0) begin errors++; $display("FAIL b2b_first got=%0d fv=%b st=%b exp=300 fv=1 st=0", value, frame_valid, stable); end
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd300 || stable !== 1'b1) begin errors++; $display("FAIL b2b_second got=%0d fv=%b st=%b exp=300 fv=1 st=1", value, frame_valid, stable); end
    send_frame(8'h81, 8'h81, 8'hCC, 8'hFF);
    idle(4);
    checks++; if (value !== 14'd400 || stable !== 1'b0) begin errors++; $display("FAIL b2b_400 got=%0d st=%b exp=400 st=0", value, stable); end
    send_frame(8'h81, 8'h81, 8'hCC, 8'hFF);
    idle(4);
    checks++; if (value !== 14'd400 || stable !== 1'b1) begin errors++; $display("FAIL b2b_400_again got=%0d st=%b exp=400 st=1", value, stable); end
    step(8'h81, 4'd4);
    checks++; if (frame_err !== 1'b1 || stable !== 1'b0 || err_count !== 8'd5) begin errors++; $display("FAIL b2b_err got fe=%b st=%b cnt=%0d exp fe=1 st=0 cnt=5", frame_err, stable, err_count); end
    checks++; if (value !== 14'd400) begin errors++; $display("FAIL b2b_err_value got=%0d exp=400", value); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] codes [4];
    logic [3:0] digs [4];
    codes = '{8'h81, 8'h81, 8'h81, 8'hCF};
    digs  = '{4'd1, 4'd2, 4'd4, 4'd8};
    send_frame(8'hA4, 8'h92, 8'hCF, 8'hFF);
    step(8'hFF, 4'd0);
    reset = 1'b1;
    step(8'hFF, 4'd0);
    reset = 1'b0;
    checks++; if (value !== 14'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || stable !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL abort_outputs got v=%0d fv=%b fe=%b st=%b cnt=%0d exp all 0", value, frame_valid, frame_err, stable, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      step(codes[i], digs[i]);
      checks++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL abort_quiet idx=%0d got fv=%b fe=%b exp 0 0", i, frame_valid, frame_err); end
    end
    idle(4);
    checks++; if (frame_valid !== 1'b1 || value !== 14'd1000) begin errors++; $display("FAIL post_reset_1000 got=%0d fv=%b exp=1000 fv=1", value, frame_valid); end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 254; i++) step(8'hFF, 4'b0011);
    checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", err_count); end
    for (int i = 0; i < 46; i++) step(8'hFF, 4'b0011);
    checks++; if (err_count !== 8'd255 || frame_err !== 1'b1) begin errors++; $display("FAIL sat_255 got cnt=%0d fe=%b exp cnt=255 fe=1", err_count, frame_err); end
    step(8'hFF, 4'd0);
    checks++; if (err_count !== 8'd255 || frame_err !== 1'b0) begin errors++; $display("FAIL sat_hold got cnt=%0d fe=%b exp cnt=255 fe=0", err_count, frame_err); end
  endtask

  initial begin
    test_reset();
    test_frame_125();
    test_frame_zero_1000();
    test_bad_slot();
    test_seq_err();
    test_back_to_back();
    test_reset_abort();
    test_err_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
